// File: rtl/param_alu_sequencer.sv
// -----------------------------------------------------------------------------
// param_alu_sequencer
//
// Board-level ALU with a button-driven load sequence. Operand A, operand B and
// the opcode are taken from the switches, one button each, in a fixed order.
// Each button is synchronised and rising-edge detected. A press is accepted
// only when it is the single button expected in the current state. Once the
// opcode is latched, the result and flags are registered on the following
// edge and o_valid pulses for one cycle.
//
// Ports
//   clk         system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_switches  operand / opcode value (opcode = low BITS_OP bits)
//   i_buttons   raw buttons: bit0 = A, bit1 = B, bit2 = OP
//   o_result    registered ALU result
//   o_flags     {Z, N, C, V}, registered with the result
//   o_valid     one-cycle strobe when result/flags update
//   o_error     high while the latched opcode is unsupported
//   o_state     00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 SHOW
// -----------------------------------------------------------------------------
module param_alu_sequencer #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6,
  parameter int BUTTONS   = 3
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic [BITS_DATA-1:0] i_switches,
  input  logic [BUTTONS-1:0]   i_buttons,
  output logic [BITS_DATA-1:0] o_result,
  output logic [3:0]           o_flags,
  output logic                 o_valid,
  output logic                 o_error,
  output logic [1:0]           o_state
);

  localparam logic [1:0] LOAD_A  = 2'b00;
  localparam logic [1:0] LOAD_B  = 2'b01;
  localparam logic [1:0] LOAD_OP = 2'b10;
  localparam logic [1:0] SHOW    = 2'b11;

  localparam logic [BITS_OP-1:0] OP_ADD = BITS_OP'(6'b100000);
  localparam logic [BITS_OP-1:0] OP_SUB = BITS_OP'(6'b100010);
  localparam logic [BITS_OP-1:0] OP_AND = BITS_OP'(6'b100100);
  localparam logic [BITS_OP-1:0] OP_OR  = BITS_OP'(6'b100101);
  localparam logic [BITS_OP-1:0] OP_XOR = BITS_OP'(6'b100110);
  localparam logic [BITS_OP-1:0] OP_NOR = BITS_OP'(6'b100111);
  localparam logic [BITS_OP-1:0] OP_SRA = BITS_OP'(6'b000011);
  localparam logic [BITS_OP-1:0] OP_SRL = BITS_OP'(6'b000010);

  localparam logic [BITS_DATA-1:0] SHIFT_LIMIT = BITS_DATA'(BITS_DATA);
  localparam int MSB = BITS_DATA - 1;

  // ---------------------------------------------------------------------------
  // Button synchronisers and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [BUTTONS-1:0] sync1, sync2, prev;
  logic [BUTTONS-1:0] press;

  // NOTE: every register uses non-blocking assignment so all flops sample the
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_buttons;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // prev resets to 0, so a button held through reset release reads as a press.
  assign press = sync2 & ~prev;

  // ---------------------------------------------------------------------------
  // Load sequencer
  // ---------------------------------------------------------------------------
  logic [1:0]           state;
  logic [BITS_DATA-1:0] a_q, b_q;
  logic [BITS_OP-1:0]   op_q;
  logic                 compute_pending;
  logic [BUTTONS-1:0]   want;
  logic                 accept;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    want = BUTTONS'(1);
    case (state)
      LOAD_B:  want = BUTTONS'(2);
      LOAD_OP: want = BUTTONS'(4);
      default: want = BUTTONS'(1);
    endcase
  end

  // Exact equality rejects simultaneous presses as well as wrong buttons.
  assign accept = (press == want);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= LOAD_A;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      compute_pending <= 1'b0;
    end else begin
      compute_pending <= 1'b0;
      if (accept) begin
        case (state)
          LOAD_A, SHOW: begin
            a_q   <= i_switches;
            state <= LOAD_B;
          end
          LOAD_B: begin
            b_q   <= i_switches;
            state <= LOAD_OP;
          end
          default: begin
            op_q            <= i_switches[BITS_OP-1:0];
            state           <= SHOW;
            compute_pending <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------------
  logic [BITS_DATA:0]   sum_ext, diff_ext;
  logic [BITS_DATA-1:0] alu_res;
  logic                 alu_c, alu_v, alu_err;
  logic                 shift_big;

  assign sum_ext   = {1'b0, a_q} + {1'b0, b_q};
  // Top bit of the extended difference is the unsigned borrow (A < B).
  assign diff_ext  = {1'b0, a_q} - {1'b0, b_q};
  assign shift_big = (b_q >= SHIFT_LIMIT);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[BITS_DATA];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[BITS_DATA];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: alu_res = shift_big ? {BITS_DATA{a_q[MSB]}}
                                  : BITS_DATA'($signed(a_q) >>> b_q);
      OP_SRL: alu_res = shift_big ? '0 : (a_q >> b_q);
      default: alu_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output registers: updated only on the edge after an opcode load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result <= '0;
      o_flags  <= 4'b0000;
      o_valid  <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      o_valid <= compute_pending;
      if (compute_pending) begin
        o_result <= alu_res;
        o_flags  <= alu_err ? 4'b0000
                            : {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
        o_error  <= alu_err;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_param_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_param_alu_sequencer
//
// Drives an 8-bit and a 16-bit instance. A behavioural model (button delay
// line, load order table and arithmetic ALU on plain integers) predicts the
// outputs of both instances; a compare process checks every output on every
// falling edge while out of reset. Directed literal checks pin the model and
// the boundary cases, followed by randomized button/switch traffic.
// -----------------------------------------------------------------------------
module tb_param_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sw0;
  logic [15:0] sw1;
  logic [2:0]  btn0, btn1;

  logic [7:0]  res0;
  logic [15:0] res1;
  logic [3:0]  flg0, flg1;
  logic        val0, val1, err0, err1;
  logic [1:0]  st0, st1;

  param_alu_sequencer #(.BITS_DATA(8), .BITS_OP(6), .BUTTONS(3)) dut8 (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_switches (sw0),
    .i_buttons  (btn0),
    .o_result   (res0),
    .o_flags    (flg0),
    .o_valid    (val0),
    .o_error    (err0),
    .o_state    (st0)
  );

  param_alu_sequencer #(.BITS_DATA(16), .BITS_OP(6), .BUTTONS(3)) dut16 (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_switches (sw1),
    .i_buttons  (btn1),
    .o_result   (res1),
    .o_flags    (flg1),
    .o_valid    (val1),
    .o_error    (err1),
    .o_state    (st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         W [2] = '{8, 16};
  int         m_state [2];
  longint     m_a [2], m_b [2], m_res [2];
  int         m_op [2], m_flg [2], m_err [2], m_val [2], m_pend [2];
  logic [2:0] hist1 [2], hist2 [2], hist3 [2];
  int         vcnt [2];

  // Arithmetic reference: operands as unsigned integers, signed view derived.
  function automatic void model_alu(input int w, input longint a, input longint b,
                                    input int op, output longint r,
                                    output int f, output int e);
    longint one, half, full, mask, sa, sb, t;
    int c, v, z, n;
    one  = 1;
    half = one << (w - 1);
    full = one << w;
    mask = full - 1;
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    c = 0; v = 0; e = 0; r = 0;
    case (op)
      32: begin
        t = a + b;
        r = t & mask;
        c = (t >= full) ? 1 : 0;
        v = ((sa + sb) >= half || (sa + sb) < -half) ? 1 : 0;
      end
      34: begin
        r = (a - b) & mask;
        c = (a < b) ? 1 : 0;
        v = ((sa - sb) >= half || (sa - sb) < -half) ? 1 : 0;
      end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = (~(a | b)) & mask;
      3:  r = (b >= w) ? ((sa < 0) ? mask : 0) : ((sa >>> b) & mask);
      2:  r = (b >= w) ? 0 : (a >> b);
      default: e = 1;
    endcase
    if (e != 0) begin
      r = 0;
      f = 0;
    end else begin
      z = (r == 0) ? 1 : 0;
      n = ((r >> (w - 1)) & 1) != 0 ? 1 : 0;
      f = (z << 3) | (n << 2) | (c << 1) | v;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_a[i] = 0; m_b[i] = 0; m_op[i] = 0; m_pend[i] = 0;
      m_res[i] = 0; m_flg[i] = 0; m_err[i] = 0; m_val[i] = 0;
      hist1[i] = '0; hist2[i] = '0; hist3[i] = '0;
    end
  endtask

  // A button level seen at edge n-2 but not at n-3 counts as a press at edge n.
  task automatic model_step(input int i);
    logic [2:0] pulse, want;
    longint sw, r;
    int f, e;
    pulse    = hist2[i] & ~hist3[i];
    hist3[i] = hist2[i];
    hist2[i] = hist1[i];
    hist1[i] = (i == 0) ? btn0 : btn1;
    sw       = (i == 0) ? longint'(sw0) : longint'(sw1);
    m_val[i] = 0;
    if (m_pend[i] != 0) begin
      model_alu(W[i], m_a[i], m_b[i], m_op[i], r, f, e);
      m_res[i]  = r;
      m_flg[i]  = f;
      m_err[i]  = e;
      m_val[i]  = 1;
      m_pend[i] = 0;
    end
    want = (m_state[i] == 1) ? 3'b010 : (m_state[i] == 2) ? 3'b100 : 3'b001;
    if (pulse == want) begin
      case (m_state[i])
        1: begin m_b[i] = sw; m_state[i] = 2; end
        2: begin m_op[i] = int'(sw & 63); m_state[i] = 3; m_pend[i] = 1; end
        default: begin m_a[i] = sw; m_state[i] = 1; end
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare process: every output of both instances on every falling edge.
  initial begin
    vcnt[0] = 0;
    vcnt[1] = 0;
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        check("res8",   res0, m_res[0]);
        check("flags8", flg0, m_flg[0]);
        check("valid8", val0, m_val[0]);
        check("error8", err0, m_err[0]);
        check("state8", st0,  m_state[0]);
        check("res16",   res1, m_res[1]);
        check("flags16", flg1, m_flg[1]);
        check("valid16", val1, m_val[1]);
        check("error16", err1, m_err[1]);
        check("state16", st1,  m_state[1]);
        if (val0) vcnt[0]++;
        if (val1) vcnt[1]++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_inputs(input int i, input logic [2:0] b, input longint v);
    if (i == 0) begin sw0 = v[7:0];  btn0 = b; end
    else        begin sw1 = v[15:0]; btn1 = b; end
  endtask

  task automatic press(input int i, input logic [2:0] b, input longint v,
                       input int hold, input int gap);
    set_inputs(i, b, v);
    repeat (hold) @(negedge clk);
    if (i == 0) btn0 = 3'b000; else btn1 = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_op(input int i, input longint a, input longint b, input int op);
    int start;
    press(i, 3'b001, a, 1, 4);
    press(i, 3'b010, b, 1, 4);
    start = vcnt[i];
    press(i, 3'b100, longint'(op), 1, 5);
    check("valid_pulse_count", vcnt[i] - start, 1);
  endtask

  task automatic expect8(input string name, input longint r, input int f, input int e);
    check({name, "_dut_res"},   res0, r);
    check({name, "_dut_flags"}, flg0, f);
    check({name, "_dut_err"},   err0, e);
    check({name, "_model_res"}, m_res[0], r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int         ops [9] = '{32, 34, 36, 37, 38, 39, 3, 2, 0};
  int         inst, pick, hold;
  logic [2:0] b;
  longint     v;

  initial begin
    rst_n = 1'b0;
    sw0 = '0; sw1 = '0; btn0 = '0; btn1 = '0;
    repeat (3) @(negedge clk);
    check("reset_res8",   res0, 0);
    check("reset_flags8", flg0, 0);
    check("reset_valid8", val0, 0);
    check("reset_state8", st0,  0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Wrong button in LOAD_A, then two buttons at once: both ignored.
    press(0, 3'b100, 64'h55, 1, 4);
    check("wrong_button_state", st0, 0);
    check("wrong_button_res",   res0, 0);
    press(0, 3'b011, 64'h55, 1, 4);
    check("double_button_state", st0, 0);

    // Held button gives a single A load.
    press(0, 3'b001, 64'h7F, 10, 4);
    check("held_button_state", st0, 1);
    press(0, 3'b010, 64'h01, 1, 4);
    press(0, 3'b100, 64'd32, 1, 5);
    expect8("add_7f_01", 64'h80, 4'b0101, 0);

    run_op(0, 64'h05, 64'h05, 34); expect8("sub_5_5",   64'h00, 4'b1000, 0);
    run_op(0, 64'h03, 64'h05, 34); expect8("sub_3_5",   64'hFE, 4'b0110, 0);
    run_op(0, 64'h90, 64'd3,  3);  expect8("sra_90_3",  64'hF2, 4'b0100, 0);
    run_op(0, 64'h90, 64'd3,  2);  expect8("srl_90_3",  64'h12, 4'b0000, 0);
    run_op(0, 64'h90, 64'd9,  3);  expect8("sra_90_9",  64'hFF, 4'b0100, 0);
    run_op(0, 64'h90, 64'd9,  2);  expect8("srl_90_9",  64'h00, 4'b1000, 0);
    run_op(0, 64'h12, 64'h34, 63); expect8("bad_op",    64'h00, 4'b0000, 1);
    run_op(0, 64'h10, 64'h20, 32); expect8("add_clears_err", 64'h30, 4'b0000, 0);

    // Reset mid-sequence, asserted between clock edges.
    press(0, 3'b001, 64'hAA, 1, 4);
    press(0, 3'b010, 64'h55, 1, 4);
    check("pre_reset_state", st0, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_res8",   res0, 0);
    check("async_reset_flags8", flg0, 0);
    check("async_reset_valid8", val0, 0);
    check("async_reset_err8",   err0, 0);
    check("async_reset_state8", st0,  0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 16-bit instance.
    run_op(1, 64'h7FFF, 64'h0001, 32);
    check("add16_res",   res1, 64'h8000);
    check("add16_flags", flg1, 4'b0101);
    check("add16_model", m_res[1], 64'h8000);

    // Randomized traffic, mostly following the expected order.
    for (int n = 0; n < 300; n++) begin
      inst = $urandom_range(0, 1);
      pick = $urandom_range(0, 9);
      if (pick < 7)
        b = (m_state[inst] == 1) ? 3'b010 : (m_state[inst] == 2) ? 3'b100 : 3'b001;
      else
        b = 3'($urandom_range(1, 7));
      if (b == 3'b100 && m_state[inst] == 2) begin
        ops[8] = $urandom_range(0, 63);
        v = longint'(ops[$urandom_range(0, 8)]) | (longint'($urandom_range(0, 3)) << 6);
      end else if (b == 3'b010 && $urandom_range(0, 1) == 1) begin
        v = longint'($urandom_range(0, W[inst] + 2));
      end else begin
        v = longint'($urandom);
      end
      hold = $urandom_range(1, 4);
      press(inst, b, v, hold, 4);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
